alu_exec_stage: RTL and testbench

- Registered execute stage of the soft processor. It consumes two 32-bit operands and an opcode from decode, and produces a registered result for writeback/memory.
- The bitwise ops are built from the team's existing 32-bit gate-level And/Or blocks.
- Single-cycle ops: AND, OR, XOR, ADD, SUB, SLT.
- Shifts are iterative, one bit per cycle, to keep area low.
- Valid/ready handshake on both sides.

---
 rtl/alu_defs_pkg.sv | 22 ++
 rtl/alu_exec_stage_comb.sv | 76 +++++++
 rtl/alu_exec_stage.sv | 124 ++++++++++++
 tb/tb_alu_exec_stage.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_defs_pkg.sv
// Shared opcode and FSM encodings for the execute stage.
package alu_defs;

    localparam logic [3:0] OP_AND = 4'd0;
    localparam logic [3:0] OP_OR  = 4'd1;
    localparam logic [3:0] OP_XOR = 4'd2;
    localparam logic [3:0] OP_ADD = 4'd3;
    localparam logic [3:0] OP_SUB = 4'd4;
    localparam logic [3:0] OP_SLT = 4'd5;
    localparam logic [3:0] OP_SLL = 4'd6;
    localparam logic [3:0] OP_SRL = 4'd7;
    localparam logic [3:0] OP_SRA = 4'd8;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SHIFT = 1'b1;

    // Shift ops are the only ones that may take more than one cycle.
    function automatic logic is_shift_op(input logic [3:0] op);
        return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
    endfunction

endpackage

// File: rtl/alu_exec_stage_comb.sv
// Gate-level bitwise blocks and the single-cycle ALU datapath.

// Per-bit AND gate array.
module And #(
    parameter int W = 32
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] y
);
    for (genvar i = 0; i < W; i++) begin : g_bit
        assign y[i] = a[i] & b[i];
    end
endmodule

// Per-bit OR gate array.
module Or #(
    parameter int W = 32
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] y
);
    for (genvar i = 0; i < W; i++) begin : g_bit
        assign y[i] = a[i] | b[i];
    end
endmodule

// Purely combinational result for every single-cycle op. Shift opcodes
// return operand A unchanged, which is the correct answer for a zero shift;
// nonzero shifts are handled by the iterative shifter in the stage.
module alu_comb_unit
    import alu_defs::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] res,
    output logic             ovf,
    output logic             illegal
);
    logic [WIDTH-1:0] and_y, or_y, sum, diff;
    logic             slt;

    And #(.W(WIDTH)) u_and (.a(a), .b(b), .y(and_y));
    Or  #(.W(WIDTH)) u_or  (.a(a), .b(b), .y(or_y));

    assign sum  = a + b;
    assign diff = a - b;
    assign slt  = $signed(a) < $signed(b);

    // Opcode select; overflow only meaningful for ADD/SUB.
    always_comb begin
        res     = '0;
        ovf     = 1'b0;
        illegal = 1'b0;
        case (op)
            OP_AND: res = and_y;
            OP_OR:  res = or_y;
            OP_XOR: res = a ^ b;
            OP_ADD: begin
                res = sum;
                ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                res = diff;
                ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SLT: res = {{(WIDTH-1){1'b0}}, slt};
            OP_SLL, OP_SRL, OP_SRA: res = a;
            default: illegal = 1'b1;
        endcase
    end
endmodule

// File: rtl/alu_exec_stage.sv
// Registered execute stage: single-cycle ALU ops plus a one-bit-per-cycle
// shifter, valid/ready on both sides, synchronous flush.
module alu_exec_stage
    import alu_defs::*;
#(
    parameter int WIDTH = 32,
    parameter int OPW   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OPW-1:0]   op,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             ovf,
    output logic             illegal
);
    logic [0:0]       state_q, state_d;
    logic [WIDTH-1:0] sh_q, sh_d, sh_next;
    logic [4:0]       cnt_q, cnt_d;
    logic [OPW-1:0]   op_q, op_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d, ovf_q, ovf_d, illegal_q, illegal_d;

    logic [WIDTH-1:0] c_res;
    logic             c_ovf, c_illegal, accept;

    alu_comb_unit #(.WIDTH(WIDTH)) u_comb (
        .op(op), .a(in1), .b(in2), .res(c_res), .ovf(c_ovf), .illegal(c_illegal)
    );

    // Flush blocks acceptance so an aborted cycle cannot start new work.
    assign in_ready = !flush && (state_q == ST_IDLE) && (!out_valid_q || out_ready);
    assign accept   = in_valid && in_ready;

    // One-bit step of the in-flight shift, direction chosen by the latched op.
    always_comb begin
        case (op_q)
            OP_SLL:  sh_next = {sh_q[WIDTH-2:0], 1'b0};
            OP_SRL:  sh_next = {1'b0, sh_q[WIDTH-1:1]};
            default: sh_next = {sh_q[WIDTH-1], sh_q[WIDTH-1:1]};
        endcase
    end

    // Next-state: flush beats accept, accept beats shift progress.
    always_comb begin
        state_d     = state_q;
        sh_d        = sh_q;
        cnt_d       = cnt_q;
        op_d        = op_q;
        out_valid_d = out_valid_q && !out_ready;
        result_d    = result_q;
        zero_d      = zero_q;
        ovf_d       = ovf_q;
        illegal_d   = illegal_q;
        if (flush) begin
            out_valid_d = 1'b0;
            state_d     = ST_IDLE;
            cnt_d       = '0;
        end else if (accept) begin
            if (is_shift_op(op) && (in2[4:0] != 5'd0)) begin
                state_d = ST_SHIFT;
                sh_d    = in1;
                cnt_d   = in2[4:0];
                op_d    = op;
            end else begin
                out_valid_d = 1'b1;
                result_d    = c_res;
                zero_d      = (c_res == '0);
                ovf_d       = c_ovf;
                illegal_d   = c_illegal;
            end
        end else if (state_q == ST_SHIFT) begin
            sh_d  = sh_next;
            cnt_d = cnt_q - 5'd1;
            if (cnt_q == 5'd1) begin
                state_d     = ST_IDLE;
                out_valid_d = 1'b1;
                result_d    = sh_next;
                zero_d      = (sh_next == '0);
                ovf_d       = 1'b0;
                illegal_d   = 1'b0;
            end
        end
    end

    // State and output registers, asynchronously cleared.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            sh_q        <= '0;
            cnt_q       <= '0;
            op_q        <= '0;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            zero_q      <= 1'b0;
            ovf_q       <= 1'b0;
            illegal_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            sh_q        <= sh_d;
            cnt_q       <= cnt_d;
            op_q        <= op_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            zero_q      <= zero_d;
            ovf_q       <= ovf_d;
            illegal_q   <= illegal_d;
        end
    end

    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign zero      = zero_q;
    assign ovf       = ovf_q;
    assign illegal   = illegal_q;
endmodule

// File: tb/tb_alu_exec_stage.sv
// Directed bench for alu_exec_stage with a transaction-level reference model
// checked every cycle, plus literal expectations at key points.
module tb_alu_exec_stage;
    import alu_defs::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  op = '0;
    logic [31:0] in1 = '0, in2 = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] result;
    logic        zero, ovf, illegal;

    int n_tests = 0;
    int n_fail  = 0;

    alu_exec_stage #(.WIDTH(32), .OPW(4)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .op(op), .in1(in1), .in2(in2),
        .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .zero(zero), .ovf(ovf), .illegal(illegal)
    );

    always #5 clk = ~clk;

    // Reference: what each opcode must produce, computed in one step.
    function automatic void golden(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                                   output logic [31:0] r, output logic v, output logic il);
        int s;
        s  = int'(b[4:0]);
        v  = 1'b0;
        il = 1'b0;
        r  = '0;
        case (o)
            4'd0: r = a & b;
            4'd1: r = a | b;
            4'd2: r = a ^ b;
            4'd3: begin r = a + b; v = (a[31] == b[31]) && (r[31] != a[31]); end
            4'd4: begin r = a - b; v = (a[31] != b[31]) && (r[31] != a[31]); end
            4'd5: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd6: r = a << s;
            4'd7: r = a >> s;
            4'd8: r = $unsigned($signed(a) >>> s);
            default: il = 1'b1;
        endcase
    endfunction

    // Model state: pending output, and remaining shift cycles.
    logic        m_vld, m_zero, m_ovf, m_ill;
    logic [31:0] m_res, m_pend;
    int          m_busy;

    function automatic logic m_ready();
        return !flush && (m_busy == 0) && (!m_vld || out_ready);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        logic [31:0] r;
        logic        v, il;
        if (!rst_n) begin
            m_vld = 0; m_res = '0; m_zero = 0; m_ovf = 0; m_ill = 0; m_busy = 0; m_pend = '0;
        end else if (flush) begin
            m_vld = 0; m_busy = 0;
        end else if (in_valid && m_ready()) begin
            golden(op, in1, in2, r, v, il);
            if ((op >= 4'd6) && (op <= 4'd8) && (in2[4:0] != 0)) begin
                m_vld = 0; m_busy = int'(in2[4:0]); m_pend = r;
            end else begin
                m_vld = 1; m_res = r; m_zero = (r == 0); m_ovf = v; m_ill = il;
            end
        end else begin
            if (m_vld && out_ready) m_vld = 0;
            if (m_busy > 0) begin
                m_busy--;
                if (m_busy == 0) begin
                    m_vld = 1; m_res = m_pend; m_zero = (m_pend == 0); m_ovf = 0; m_ill = 0;
                end
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (rst_n) begin
            n_tests++;
            if (in_ready !== m_ready() || out_valid !== m_vld || result !== m_res ||
                zero !== m_zero || ovf !== m_ovf || illegal !== m_ill) begin
                n_fail++;
                $display("FAIL model t=%0t: got rdy=%b vld=%b res=%h z=%b o=%b il=%b, want rdy=%b vld=%b res=%h z=%b o=%b il=%b",
                         $time, in_ready, out_valid, result, zero, ovf, illegal,
                         m_ready(), m_vld, m_res, m_zero, m_ovf, m_ill);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h", name, got, exp);
        end
    endtask

    // Present a transaction and hold it until accepted; returns at edge+1.
    task automatic send(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
        logic r;
        bit   ok;
        ok = 0;
        op = o; in1 = a; in2 = b; in_valid = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk); r = in_ready;
            @(posedge clk); #1;
            if (r) begin ok = 1; break; end
        end
        if (!ok) begin
            n_tests++; n_fail++;
            $display("FAIL accept_timeout: op %0d not accepted within 20 cycles", o);
        end
    endtask

    task automatic idle_cycles(input int n);
        in_valid = 1'b0;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    initial begin
        logic [31:0] r;
        logic        v, il;
        int          lat;
        int          rises;

        // Pin the model with hand-computed values.
        golden(OP_ADD, 32'h7FFF_FFFF, 32'd1, r, v, il);
        check("gold_add", {r[31:1], r[0] ^ v}, 32'h8000_0001);
        golden(OP_SRA, 32'h8000_0010, 32'd4, r, v, il);
        check("gold_sra", r, 32'hF800_0001);

        // Reset state.
        #2;
        check("rst_vld", {31'b0, out_valid}, 32'd0);
        check("rst_res", result, 32'd0);
        check("rst_flags", {29'b0, zero, ovf, illegal}, 32'd0);
        #10 rst_n = 1'b1;
        #1 check("rst_rdy", {31'b0, in_ready}, 32'd1);
        @(posedge clk); #1;

        // Back-to-back AND then OR.
        send(OP_AND, 32'hF0F0_F0F0, 32'hFF00_FF00);
        check("and_res", result, 32'hF000_F000);
        check("and_vld", {31'b0, out_valid}, 32'd1);
        send(OP_OR, 32'hF0F0_F0F0, 32'hFF00_FF00);
        check("or_res", result, 32'hFFF0_FFF0);

        send(OP_ADD, 32'h7FFF_FFFF, 32'd1);
        check("add_ovf", {result[31:1], ovf}, {31'h4000_0000, 1'b1});
        send(OP_SUB, 32'd5, 32'd5);
        check("sub_zero", {result[31:2], zero, ovf}, 32'h0000_0002);
        send(OP_SLT, 32'hFFFF_FFFF, 32'd1);
        check("slt", result, 32'd1);

        // SRA by 4: exactly 4 cycles of latency.
        send(OP_SRA, 32'h8000_0010, 32'd4);
        in_valid = 1'b0;
        lat = 0;
        for (int k = 0; k < 40; k++) begin
            if (out_valid) break;
            check("sra_busy_rdy", {31'b0, in_ready}, 32'd0);
            @(posedge clk); #1; lat++;
        end
        check("sra_lat", lat, 32'd4);
        check("sra_res", result, 32'hF800_0001);

        send(OP_SLL, 32'h1234_5678, 32'd0);
        check("sll0_res", result, 32'h1234_5678);
        check("sll0_vld", {31'b0, out_valid}, 32'd1);

        // Backpressure: result held, pending XOR not consumed.
        idle_cycles(1);
        out_ready = 1'b0;
        send(OP_ADD, 32'd1, 32'd2);
        op = OP_XOR; in1 = 32'd6; in2 = 32'd3; in_valid = 1'b1;
        repeat (5) begin @(posedge clk); #1; end
        check("bp_hold", result, 32'd3);
        check("bp_rdy", {30'b0, out_valid, in_ready}, 32'd2);
        out_ready = 1'b1;
        send(OP_XOR, 32'd6, 32'd3);
        check("bp_next", result, 32'd5);

        // Flush on the third cycle of SLL by 10.
        send(OP_SLL, 32'd1, 32'd10);
        idle_cycles(2);
        flush = 1'b1; op = OP_AND; in1 = '1; in2 = '1; in_valid = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        rises = 0;
        repeat (12) begin
            if (out_valid) rises++;
            @(posedge clk); #1;
        end
        check("flush_novld", rises, 32'd0);
        check("flush_keep", result, 32'd5);
        check("flush_rdy", {31'b0, in_ready}, 32'd1);
        send(OP_AND, 32'hFFFF_0000, 32'h0FF0_0FF0);
        check("post_flush_and", result, 32'h0FF0_0000);

        send(4'd12, 32'hDEAD_BEEF, 32'd7);
        check("illegal", {result[31:2], illegal, zero}, 32'd3);

        // Asynchronous reset in the middle of a shift.
        send(OP_OR, 32'd0, 32'h1234);
        send(OP_SRL, 32'hFFFF_FFFF, 32'd20);
        idle_cycles(3);
        #2 rst_n = 1'b0;
        #1;
        check("amid_vld", {31'b0, out_valid}, 32'd0);
        check("amid_res", result, 32'd0);
        #3 rst_n = 1'b1;
        #1 check("amid_rdy", {31'b0, in_ready}, 32'd1);
        @(posedge clk); #1;
        send(OP_ADD, 32'hFFFF_FFFF, 32'd1);
        check("post_rst_add", {result[31:2], zero, ovf}, 32'd2);
        idle_cycles(3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
